// File: rtl/sample_window_counter.sv
// sample_window_counter: per-channel sample-strobe window counters with sticky done/overrun,
// programmable shared threshold and periodic or one-shot windows.
module sample_window_counter #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [NUM_CH-1:0]             cnt_up,
    input  logic [NUM_CH-1:0]             clear,
    input  logic [NUM_CH-1:0]             ack,
    input  logic [CNT_WIDTH-1:0]          threshold,
    input  logic                          periodic,
    output logic [NUM_CH*CNT_WIDTH-1:0]   count_out,
    output logic [NUM_CH-1:0]             done,
    output logic [NUM_CH-1:0]             overrun,
    output logic                          any_done,
    output logic                          all_done
);
    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 done_q, ovr_q, en, at_th, fin;
        assign en    = cnt_up[i] && threshold != '0;
        assign at_th = cnt_q >= threshold;
        // a window completes on reaching threshold, or on a periodic roll when threshold is 1
        assign fin   = en && (at_th ? periodic && threshold == CNT_WIDTH'(1)
                                    : CNT_WIDTH'(cnt_q + 1'b1) == threshold);
        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else if (clear[i]) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                if (en)
                    cnt_q <= at_th ? (periodic ? CNT_WIDTH'(1) : cnt_q) : CNT_WIDTH'(cnt_q + 1'b1);
                done_q <= fin | (done_q & ~ack[i]);
                ovr_q  <= ovr_q | (fin & done_q & ~ack[i]) | (en & at_th & ~periodic);
            end
        end
        assign count_out[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign done[i]    = done_q;
        assign overrun[i] = ovr_q;
    end
    assign any_done = |done;
    assign all_done = &done;
endmodule

// File: tb/tb_sample_window_counter.sv
// tb_sample_window_counter: directed and random stimulus, behavioural model feeding a
// scoreboard queue that a separate monitor drains once per clock.
module tb_sample_window_counter;
    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0, n_reset = 1'b0, periodic = 1'b0;
    logic [N-1:0]   cnt_up = '0, clear = '0, ack = '0;
    logic [W-1:0]   threshold = '0;
    logic [N*W-1:0] count_out;
    logic [N-1:0]   done, overrun;
    logic           any_done, all_done;

    sample_window_counter #(.NUM_CH(N), .CNT_WIDTH(W)) dut (
        .clk(clk), .n_reset(n_reset), .cnt_up(cnt_up), .clear(clear), .ack(ack),
        .threshold(threshold), .periodic(periodic), .count_out(count_out),
        .done(done), .overrun(overrun), .any_done(any_done), .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   d;
        logic [N-1:0]   o;
    } exp_t;

    exp_t q[$];
    int   m_cnt[N];
    bit   m_done[N], m_ovr[N];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] cnt_of(input int ch);
        return count_out[ch*W +: W];
    endfunction

    function automatic exp_t snap();
        exp_t e;
        for (int c = 0; c < N; c++) begin
            e.cnt[c*W +: W] = W'(m_cnt[c]);
            e.d[c] = m_done[c];
            e.o[c] = m_ovr[c];
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0;
            m_done[c] = 0;
            m_ovr[c] = 0;
        end
    endfunction

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic step(input logic [N-1:0] cu, input logic [N-1:0] cl, input logic [N-1:0] ak,
                        input int th, input bit per);
        @(negedge clk);
        cnt_up = cu; clear = cl; ack = ak; threshold = W'(th); periodic = per;
        for (int c = 0; c < N; c++) begin
            bit comp = 0;
            if (cl[c]) begin
                m_cnt[c] = 0; m_done[c] = 0; m_ovr[c] = 0;
                continue;
            end
            if (cu[c] && th > 0) begin
                if (m_cnt[c] < th) begin
                    m_cnt[c]++;
                    comp = (m_cnt[c] == th);
                end else if (per) begin
                    m_cnt[c] = 1;
                    comp = (th == 1);
                end else
                    m_ovr[c] = 1;
            end
            if (comp) begin
                if (m_done[c] && !ak[c]) m_ovr[c] = 1;
                m_done[c] = 1;
            end else if (ak[c])
                m_done[c] = 0;
        end
        q.push_back(snap());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge with reset released, compare against the oldest prediction.
    always begin
        @(posedge clk);
        #1;
        if (n_reset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_count", 64'(count_out), 64'(e.cnt));
            chk("sb_done", 64'(done), 64'(e.d));
            chk("sb_overrun", 64'(overrun), 64'(e.o));
            chk("sb_any_done", 64'(any_done), 64'(|e.d));
            chk("sb_all_done", 64'(all_done), 64'(&e.d));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int th;
        bit per;
        model_reset();
        #12;
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_flags", {done, overrun, any_done, all_done}, 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // one-shot window of 1000 on ch0
        for (int k = 0; k < 1000; k++) step(4'b0001, '0, '0, 1000, 0);
        settle();
        chk("os_count0", 64'(cnt_of(0)), 64'd1000);
        chk("os_done", 64'(done), 64'b0001);
        chk("os_any_all", {any_done, all_done}, 64'b10);
        chk("os_others", 64'(count_out[N*W-1:W]), 64'd0);
        step(4'b0001, '0, '0, 1000, 0);
        settle();
        chk("os_drop_count", 64'(cnt_of(0)), 64'd1000);
        chk("os_drop_ovr", 64'(overrun), 64'b0001);
        step('0, '0, 4'b0001, 1000, 0);
        settle();
        chk("os_ack", {done, overrun}, {4'b0000, 4'b0001});
        step('0, 4'b0001, '0, 1000, 0);
        settle();
        chk("os_clear", {64'(cnt_of(0)), 4'(done), 4'(overrun)}, 72'd0);

        // periodic, threshold 3 on ch1
        for (int k = 1; k <= 7; k++) begin
            step(4'b0010, '0, '0, 3, 1);
            settle();
            chk("per_count1", 64'(cnt_of(1)), 64'(((k - 1) % 3) + 1));
            if (k == 3) chk("per_done3", 64'(done[1]), 64'd1);
            if (k == 5) chk("per_ovr5", 64'(overrun[1]), 64'd0);
            if (k == 6) chk("per_ovr6", 64'(overrun[1]), 64'd1);
        end

        // ack coincident with completion on ch2, then clear beats cnt_up
        step(4'b0100, '0, '0, 3, 1);
        step(4'b0100, '0, '0, 3, 1);
        step(4'b0100, '0, 4'b0100, 3, 1);
        settle();
        chk("ack_set_wins", {done[2], overrun[2]}, 64'b10);
        step(4'b0100, 4'b0100, '0, 3, 1);
        settle();
        chk("clear_wins", 64'(cnt_of(2)), 64'd0);

        // disabled channels, then threshold lowered under the count
        step('0, '1, '0, 3, 1);
        for (int k = 0; k < 3; k++) step('1, '0, '0, 0, 1);
        settle();
        chk("th0_count", 64'(count_out), 64'd0);
        chk("th0_flags", {done, overrun}, 64'd0);
        for (int k = 0; k < 6; k++) step(4'b1000, '0, '0, 10, 1);
        step(4'b1000, '0, '0, 4, 1);
        settle();
        chk("lowered_roll", 64'(cnt_of(3)), 64'd1);

        // asynchronous reset mid-window
        step('0, '1, '0, 1000, 0);
        for (int k = 0; k < 500; k++) step('1, '0, '0, 1000, 0);
        settle();
        chk("pre_rst_count", 64'(cnt_of(2)), 64'd500);
        @(negedge clk);
        cnt_up = '0;
        #2 n_reset = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_out), 64'd0);
        chk("async_rst_flags", {done, overrun, any_done, all_done}, 64'd0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
        step('1, '0, '0, 2, 0);
        step('1, '0, '0, 2, 0);
        settle();
        chk("post_rst_all_done", 64'(all_done), 64'd1);

        // randomized traffic
        th = 3; per = 1;
        step('0, '1, '0, th, per);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 40) == 0) begin
                case ($urandom_range(0, 5))
                    0: th = 0;
                    1: th = 1;
                    2: th = 2;
                    3: th = 1023;
                    default: th = $urandom_range(3, 8);
                endcase
            end
            if ($urandom_range(0, 60) == 0) per = ~per;
            step(N'($urandom) & N'($urandom | $urandom),
                 ($urandom_range(0, 30) == 0) ? N'($urandom) : '0,
                 N'($urandom) & N'($urandom), th, per);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
